// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, IR field positions, sequencer states, ALU codes.
package cpu_defs_pkg;

  localparam int OP_W      = 5;
  localparam int FLD_W     = 4;
  localparam int IR_OP_MSB = 31;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RC_MSB = 18;

  // Opcodes (IR[31:27])
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01000;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01001;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01010;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01100;
  localparam logic [OP_W-1:0] OP_LD   = 5'b01101;
  localparam logic [OP_W-1:0] OP_ST   = 5'b01110;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // ALU operation codes; register-form ALU ops use the opcode value directly
  localparam logic [OP_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [OP_W-1:0] ALU_AND = 5'b00010;
  localparam logic [OP_W-1:0] ALU_OR  = 5'b00011;

  typedef enum logic [3:0] {
    ST_RESET, ST_FETCH0, ST_FETCH1, ST_FETCH2, ST_FETCH3,
    ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALUR, CLS_ALUI, CLS_MULDIV, CLS_LD, CLS_ST, CLS_NOP, CLS_HALT, CLS_ILL
  } op_class_t;

  // Group opcodes by the execute sequence they follow
  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    op_class_t c;
    if (op <= OP_ROL) c = CLS_ALUR;
    else begin
      case (op)
        OP_ADDI, OP_ANDI, OP_ORI: c = CLS_ALUI;
        OP_MUL, OP_DIV:           c = CLS_MULDIV;
        OP_LD:                    c = CLS_LD;
        OP_ST:                    c = CLS_ST;
        OP_NOP:                   c = CLS_NOP;
        OP_HALT:                  c = CLS_HALT;
        default:                  c = CLS_ILL;
      endcase
    end
    return c;
  endfunction

  // Immediate forms reuse the register-form ALU op of the same operation
  function automatic logic [OP_W-1:0] alui_op(input logic [OP_W-1:0] op);
    logic [OP_W-1:0] a;
    case (op)
      OP_ANDI: a = ALU_AND;
      OP_ORI:  a = ALU_OR;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register field to one-hot select decoder with enable.
module reg_select_decoder #(
  parameter int NREG = 16,
  parameter int SELW = 4
) (
  input  logic            i_en,
  input  logic [SELW-1:0] i_sel,
  output logic [NREG-1:0] o_onehot
);

  // One comparator per register; all zero when disabled
  for (genvar i = 0; i < NREG; i++) begin : g_bit
    assign o_onehot[i] = i_en & (int'(i_sel) == i);
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch, decode, execute one instruction at a time.
module control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  input  logic            stop,
  output logic [NREG-1:0] r_in,
  output logic [NREG-1:0] r_out,
  output logic            PCin,
  output logic            PCout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            HIin,
  output logic            LOin,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            IncPC,
  output logic            Cout,
  output logic            Read,
  output logic            Write,
  output logic [OPW-1:0]  alu_op,
  output logic            run,
  output logic            illegal_op
);

  state_t           r_state, w_next;
  logic [OPW-1:0]   w_op;
  logic [FLD_W-1:0] w_ra, w_rb, w_rc;
  op_class_t        w_cls;
  logic             w_in_en, w_out_en;
  logic [FLD_W-1:0] w_in_sel, w_out_sel;
  logic             w_unused_ir;

  assign w_op        = ir[IR_OP_MSB -: OPW];
  assign w_ra        = ir[IR_RA_MSB -: FLD_W];
  assign w_rb        = ir[IR_RB_MSB -: FLD_W];
  assign w_rc        = ir[IR_RC_MSB -: FLD_W];
  assign w_cls       = op_class(w_op);
  assign w_unused_ir = ^ir[IR_RC_MSB-FLD_W:0];

  // State register; clr overrides everything, including wait states
  always_ff @(posedge clk) begin
    if (clr) r_state <= ST_RESET;
    else     r_state <= w_next;
  end

  // Next-state: fetch, then a class-specific execute tail back to FETCH0
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:  w_next = ST_FETCH0;
      ST_FETCH0: w_next = stop ? ST_HALT : ST_FETCH1;
      ST_FETCH1: w_next = ST_FETCH2;
      ST_FETCH2: w_next = mem_ready ? ST_FETCH3 : ST_FETCH2;
      ST_FETCH3: w_next = ST_T3;
      ST_T3: begin
        case (w_cls)
          CLS_ALUR, CLS_ALUI, CLS_MULDIV, CLS_LD, CLS_ST: w_next = ST_T4;
          CLS_HALT: w_next = ST_HALT;
          default:  w_next = ST_FETCH0;
        endcase
      end
      ST_T4: w_next = ST_T5;
      ST_T5: w_next = (w_cls inside {CLS_MULDIV, CLS_LD, CLS_ST}) ? ST_T6 : ST_FETCH0;
      ST_T6: begin
        case (w_cls)
          CLS_LD:  w_next = mem_ready ? ST_T7 : ST_T6;
          CLS_ST:  w_next = ST_T7;
          default: w_next = ST_FETCH0;
        endcase
      end
      ST_T7: begin
        if (w_cls == CLS_ST) w_next = mem_ready ? ST_FETCH0 : ST_T7;
        else                 w_next = ST_FETCH0;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RESET;
    endcase
  end

  // Output decode from state and IR; everything defaults to idle
  always_comb begin
    PCin = 1'b0; PCout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; HIin = 1'b0; LOin = 1'b0;
    Zhighout = 1'b0; Zlowout = 1'b0; IncPC = 1'b0; Cout = 1'b0;
    Read = 1'b0; Write = 1'b0; alu_op = ALU_ADD; illegal_op = 1'b0;
    w_in_en = 1'b0; w_in_sel = w_ra; w_out_en = 1'b0; w_out_sel = w_rb;
    run = (r_state != ST_RESET) && (r_state != ST_HALT);
    case (r_state)
      ST_FETCH0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_FETCH1: begin Zlowout = 1'b1; PCin = 1'b1; end
      ST_FETCH2: begin Read = 1'b1; MDRin = 1'b1; end
      ST_FETCH3: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (w_cls)
          CLS_ALUR, CLS_ALUI, CLS_LD, CLS_ST: begin w_out_en = 1'b1; w_out_sel = w_rb; Yin = 1'b1; end
          CLS_MULDIV: begin w_out_en = 1'b1; w_out_sel = w_ra; Yin = 1'b1; end
          CLS_ILL:    illegal_op = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        case (w_cls)
          CLS_ALUR:   begin w_out_en = 1'b1; w_out_sel = w_rc; alu_op = w_op; Zin = 1'b1; end
          CLS_ALUI:   begin Cout = 1'b1; alu_op = alui_op(w_op); Zin = 1'b1; end
          CLS_MULDIV: begin w_out_en = 1'b1; w_out_sel = w_rb; alu_op = w_op; Zin = 1'b1; end
          CLS_LD, CLS_ST: begin Cout = 1'b1; Zin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (w_cls)
          CLS_ALUR, CLS_ALUI: begin Zlowout = 1'b1; w_in_en = 1'b1; end
          CLS_MULDIV:         begin Zlowout = 1'b1; LOin = 1'b1; end
          CLS_LD, CLS_ST:     begin Zlowout = 1'b1; MARin = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (w_cls)
          CLS_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
          CLS_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          // Store data enters MDR from the bus, not from memory
          CLS_ST:     begin w_out_en = 1'b1; w_out_sel = w_ra; MDRin = 1'b1; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (w_cls)
          CLS_LD:  begin MDRout = 1'b1; w_in_en = 1'b1; end
          CLS_ST:  Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  reg_select_decoder #(.NREG(NREG), .SELW(FLD_W)) u_in_dec (
    .i_en(w_in_en), .i_sel(w_in_sel), .o_onehot(r_in)
  );

  reg_select_decoder #(.NREG(NREG), .SELW(FLD_W)) u_out_dec (
    .i_en(w_out_en), .i_sel(w_out_sel), .o_onehot(r_out)
  );

endmodule
